// File: rtl/rambus_arbiter.sv
// Two-master round-robin arbiter for the shared OpenRAM Wishbone port.
// Holds a grant for the owner's bus cycle, caps bursts and aborts stalled cycles.
module rambus_arbiter #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              m0_wb_cyc_i,
  input  logic              m0_wb_stb_i,
  input  logic              m0_wb_we_i,
  input  logic [3:0]        m0_wb_sel_i,
  input  logic [31:0]       m0_wb_dat_i,
  input  logic [ADDR_W-1:0] m0_wb_adr_i,
  output logic              m0_wb_ack_o,
  output logic              m0_wb_err_o,
  output logic [31:0]       m0_wb_dat_o,
  input  logic              m1_wb_cyc_i,
  input  logic              m1_wb_stb_i,
  input  logic              m1_wb_we_i,
  input  logic [3:0]        m1_wb_sel_i,
  input  logic [31:0]       m1_wb_dat_i,
  input  logic [ADDR_W-1:0] m1_wb_adr_i,
  output logic              m1_wb_ack_o,
  output logic              m1_wb_err_o,
  output logic [31:0]       m1_wb_dat_o,
  output logic              rambus_wb_clk_o,
  output logic              rambus_wb_rst_o,
  output logic              rambus_wb_cyc_o,
  output logic              rambus_wb_stb_o,
  output logic              rambus_wb_we_o,
  output logic [3:0]        rambus_wb_sel_o,
  output logic [31:0]       rambus_wb_dat_o,
  output logic [ADDR_W-1:0] rambus_wb_adr_o,
  input  logic              rambus_wb_ack_i,
  input  logic [31:0]       rambus_wb_dat_i,
  output logic [1:0]        grant_o
);

  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned TO_W    = 8;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t             state, state_d;
  logic               last, last_d;
  logic [BURST_W-1:0] burst_cnt, burst_d;
  logic [TO_W-1:0]    to_cnt, to_d;

  logic               req0, req1, sel1;
  logic               own_cyc, own_stb, own_we, other_req;
  logic [3:0]         own_sel;
  logic [31:0]        own_dat;
  logic [ADDR_W-1:0]  own_adr;
  logic               timeout, ack, rel;

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_ni;

  assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1 = m1_wb_cyc_i & m1_wb_stb_i;
  assign sel1 = (state == OWN1);
  assign grant_o = {state == OWN1, state == OWN0};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      burst_cnt <= burst_d;
      to_cnt    <= to_d;
    end
  end

  // Owner mux, counters and release decision
  always_comb begin
    state_d = state;
    last_d  = last;
    burst_d = burst_cnt;
    to_d    = to_cnt;

    rambus_wb_cyc_o = 1'b0;
    rambus_wb_stb_o = 1'b0;
    rambus_wb_we_o  = 1'b0;
    rambus_wb_sel_o = '0;
    rambus_wb_dat_o = '0;
    rambus_wb_adr_o = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m0_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    m1_wb_dat_o = '0;

    own_cyc   = sel1 ? m1_wb_cyc_i : m0_wb_cyc_i;
    own_stb   = sel1 ? m1_wb_stb_i : m0_wb_stb_i;
    own_we    = sel1 ? m1_wb_we_i  : m0_wb_we_i;
    own_sel   = sel1 ? m1_wb_sel_i : m0_wb_sel_i;
    own_dat   = sel1 ? m1_wb_dat_i : m0_wb_dat_i;
    own_adr   = sel1 ? m1_wb_adr_i : m0_wb_adr_i;
    other_req = sel1 ? req0 : req1;

    timeout = 1'b0;
    ack     = 1'b0;
    rel     = 1'b0;

    if (state == IDLE) begin
      burst_d = '0;
      to_d    = '0;
      if (req0 && (!req1 || last)) begin
        state_d = OWN0;
      end else if (req1) begin
        state_d = OWN1;
      end
    end else begin
      timeout = own_stb && (to_cnt == TO_LAST);
      ack     = rambus_wb_ack_i && !timeout;

      rambus_wb_cyc_o = own_cyc;
      rambus_wb_stb_o = own_stb && !timeout;
      rambus_wb_we_o  = own_we;
      rambus_wb_sel_o = own_sel;
      rambus_wb_dat_o = own_dat;
      rambus_wb_adr_o = own_adr;

      if (sel1) begin
        m1_wb_ack_o = ack;
        m1_wb_err_o = timeout;
        m1_wb_dat_o = rambus_wb_dat_i;
      end else begin
        m0_wb_ack_o = ack;
        m0_wb_err_o = timeout;
        m0_wb_dat_o = rambus_wb_dat_i;
      end

      // Burst count saturates at the last slot so a late requester still forces hand-over
      if (ack && (burst_cnt != BURST_LAST)) begin
        burst_d = burst_cnt + BURST_W'(1);
      end

      if (!own_stb || ack) begin
        to_d = '0;
      end else begin
        to_d = to_cnt + TO_W'(1);
      end

      rel = !own_cyc || timeout || (ack && (burst_cnt == BURST_LAST) && other_req);
      if (rel) begin
        state_d = IDLE;
        last_d  = sel1;
      end
    end
  end

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed bench for rambus_arbiter: single transfer, ties, burst cap, timeout, async reset.
module tb_rambus_arbiter;

  localparam int unsigned ADDR_W = 10;

  logic              clk, rst_n;
  logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]        m0_sel, m1_sel;
  logic [31:0]       m0_wdat, m1_wdat, m0_rdat, m1_rdat;
  logic [ADDR_W-1:0] m0_adr, m1_adr;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic              rb_clk, rb_rst, rb_cyc, rb_stb, rb_we;
  logic [3:0]        rb_sel;
  logic [31:0]       rb_wdat;
  logic [ADDR_W-1:0] rb_adr;
  logic              ram_ack, ram_en;
  logic [31:0]       ram_dat;
  logic [1:0]        grant;

  int vectors = 0;
  int errors  = 0;

  rambus_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(16), .TIMEOUT_CYC(255)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_sel_i(m0_sel),
    .m0_wb_dat_i(m0_wdat), .m0_wb_adr_i(m0_adr), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
    .m0_wb_dat_o(m0_rdat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_sel_i(m1_sel),
    .m1_wb_dat_i(m1_wdat), .m1_wb_adr_i(m1_adr), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
    .m1_wb_dat_o(m1_rdat),
    .rambus_wb_clk_o(rb_clk), .rambus_wb_rst_o(rb_rst), .rambus_wb_cyc_o(rb_cyc),
    .rambus_wb_stb_o(rb_stb), .rambus_wb_we_o(rb_we), .rambus_wb_sel_o(rb_sel),
    .rambus_wb_dat_o(rb_wdat), .rambus_wb_adr_o(rb_adr), .rambus_wb_ack_i(ram_ack),
    .rambus_wb_dat_i(ram_dat), .grant_o(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: acks one cycle after a strobe, read data tagged with the address
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ack <= 1'b0;
      ram_dat <= '0;
    end else begin
      ram_ack <= ram_en & rb_cyc & rb_stb & ~ram_ack;
      ram_dat <= 32'hC0DE_0000 | 32'(rb_adr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_wdat = '0; m0_adr = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_wdat = '0; m1_adr = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; ram_en = 1; idle_masters();
    m0_cyc = 1; m0_stb = 1; m0_adr = 10'h004;
    #3;
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b exp 00", grant); end
    vectors++; if ({rb_cyc, rb_stb, rb_we, rb_sel, rb_wdat, rb_adr} !== '0) begin
      errors++; $display("FAIL rst_rambus: got cyc=%b stb=%b adr=%h exp all 0", rb_cyc, rb_stb, rb_adr); end
    vectors++; if ({m0_ack, m0_err, m1_ack, m1_err, m0_rdat, m1_rdat} !== '0) begin
      errors++; $display("FAIL rst_master_out: got ack0=%b err0=%b dat0=%h exp 0", m0_ack, m0_err, m0_rdat); end
    vectors++; if (rb_rst !== 1'b1) begin errors++; $display("FAIL rst_rambus_rst: got %b exp 1", rb_rst); end
    tick();
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant_edge: got %b exp 00", grant); end
    idle_masters();
    rst_n = 1;
    tick();
    vectors++; if (rb_rst !== 1'b0) begin errors++; $display("FAIL rst_release: got %b exp 0", rb_rst); end
  endtask

  task automatic test_single_write();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_wdat = 32'hDEAD_BEEF; m0_adr = 10'h010;
    #1;
    vectors++; if (grant !== 2'b00 || rb_cyc !== 1'b0) begin
      errors++; $display("FAIL t1_latency: got grant=%b cyc=%b exp 00/0", grant, rb_cyc); end
    tick(); #1;
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL t1_grant: got %b exp 01", grant); end
    vectors++; if (rb_adr !== 10'h010 || rb_wdat !== 32'hDEAD_BEEF || rb_we !== 1'b1 || rb_stb !== 1'b1 || rb_sel !== 4'hF) begin
      errors++; $display("FAIL t1_fwd: got adr=%h dat=%h we=%b stb=%b sel=%h exp 010/deadbeef/1/1/f", rb_adr, rb_wdat, rb_we, rb_stb, rb_sel); end
    vectors++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL t1_early_ack: got %b exp 0", m0_ack); end
    tick();
    // master drops cyc in the same cycle the RAM acks
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1;
    vectors++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL t1_ack: got ack0=%b ack1=%b exp 1/0", m0_ack, m1_ack); end
    tick(); #1;
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL t1_release: got %b exp 00", grant); end
    tick();
  endtask

  task automatic test_tie_round_robin();
    rst_n = 0; idle_masters(); tick(); rst_n = 1; tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 10'h020;
    m1_cyc = 1; m1_stb = 1; m1_adr = 10'h030;
    tick(); #1;
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL t2_first: got %b exp 01", grant); end
    tick(); #1;
    vectors++; if (m0_ack !== 1'b1 || m0_rdat !== 32'hC0DE_0020 || m1_ack !== 1'b0) begin
      errors++; $display("FAIL t2_m0_read: got ack=%b dat=%h ack1=%b exp 1/c0de0020/0", m0_ack, m0_rdat, m1_ack); end
    tick();
    m0_cyc = 0; m0_stb = 0;
    #1;
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL t2_drop: got %b exp 01", grant); end
    tick(); #1;
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL t2_idle: got %b exp 00", grant); end
    tick(); #1;
    vectors++; if (grant !== 2'b10) begin errors++; $display("FAIL t2_m1_grant: got %b exp 10", grant); end
    tick(); #1;
    vectors++; if (m1_ack !== 1'b1 || m1_rdat !== 32'hC0DE_0030) begin
      errors++; $display("FAIL t2_m1_read: got ack=%b dat=%h exp 1/c0de0030", m1_ack, m1_rdat); end
    tick();
    m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    #1;
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL t2_idle2: got %b exp 00", grant); end
    tick(); #1;
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL t2_next_tie: got %b exp 01", grant); end
    tick();
    idle_masters();
    tick(); tick();
  endtask

  task automatic test_burst_cap();
    int m1_n = 0;
    int m1_before_m0 = -1;
    int bad_grant = 0;
    bit m0_done = 0;
    bit adv, drop0;
    int cyc_cnt = 0;
    logic [ADDR_W-1:0] a;
    m1_cyc = 1; m1_stb = 1; m1_adr = 10'h200;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 10'h100;
    while (!(m1_n == 40 && m0_done) && cyc_cnt < 400) begin
      adv = 0; drop0 = 0;
      #1;
      if (m1_ack) begin
        if (grant !== 2'b10) bad_grant++;
        a = 10'(10'h200 + 4 * m1_n);
        vectors++; if (m1_rdat !== (32'hC0DE_0000 | 32'(a))) begin
          errors++; $display("FAIL t3_word%0d: got %h exp %h", m1_n, m1_rdat, 32'hC0DE_0000 | 32'(a)); end
        m1_n++; adv = 1;
      end
      if (m0_ack) begin
        vectors++; if (m0_rdat !== 32'hC0DE_0100) begin
          errors++; $display("FAIL t3_m0_data: got %h exp c0de0100", m0_rdat); end
        m0_done = 1; m1_before_m0 = m1_n; drop0 = 1;
      end
      tick();
      cyc_cnt++;
      if (adv) begin
        if (m1_n == 40) begin m1_cyc = 0; m1_stb = 0; end
        else m1_adr = 10'(10'h200 + 4 * m1_n);
      end
      if (drop0) begin m0_cyc = 0; m0_stb = 0; end
    end
    vectors++; if (m1_n != 40 || !m0_done) begin
      errors++; $display("FAIL t3_complete: got m1 words=%0d m0 done=%0d exp 40/1", m1_n, m0_done); end
    vectors++; if (m1_before_m0 != 16) begin
      errors++; $display("FAIL t3_burst_cap: got %0d m1 acks before m0 exp 16", m1_before_m0); end
    vectors++; if (bad_grant != 0) begin
      errors++; $display("FAIL t3_ack_grant: got %0d m1 acks outside OWN1 exp 0", bad_grant); end
    idle_masters();
    tick(); tick();
  endtask

  task automatic test_timeout();
    int err_early = 0;
    ram_en = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 10'h040;
    tick();
    for (int k = 1; k <= 254; k++) begin
      if (k == 1) begin m1_cyc = 1; m1_stb = 1; m1_adr = 10'h050; end
      #1;
      if (m0_err || m1_err || grant !== 2'b01) err_early++;
      tick();
    end
    vectors++; if (err_early != 0) begin
      errors++; $display("FAIL t4_early: got %0d bad cycles before timeout exp 0", err_early); end
    #1;
    vectors++; if (m0_err !== 1'b1 || m1_err !== 1'b0) begin
      errors++; $display("FAIL t4_err: got err0=%b err1=%b exp 1/0", m0_err, m1_err); end
    vectors++; if (rb_stb !== 1'b0 || rb_cyc !== 1'b1 || grant !== 2'b01) begin
      errors++; $display("FAIL t4_stb_mask: got stb=%b cyc=%b grant=%b exp 0/1/01", rb_stb, rb_cyc, grant); end
    tick();
    m0_cyc = 0; m0_stb = 0;
    #1;
    vectors++; if (grant !== 2'b00 || m0_err !== 1'b0) begin
      errors++; $display("FAIL t4_release: got grant=%b err=%b exp 00/0", grant, m0_err); end
    tick(); #1;
    vectors++; if (grant !== 2'b10) begin errors++; $display("FAIL t4_m1_next: got %b exp 10", grant); end
    ram_en = 1;
    tick(); tick();
    idle_masters();
    tick(); tick();
  endtask

  task automatic test_async_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 10'h060;
    tick(); #1;
    vectors++; if (grant !== 2'b10) begin errors++; $display("FAIL t5_own1: got %b exp 10", grant); end
    rst_n = 0;
    #1;
    vectors++; if (grant !== 2'b00 || rb_cyc !== 1'b0 || rb_stb !== 1'b0) begin
      errors++; $display("FAIL t5_async: got grant=%b cyc=%b stb=%b exp 00/0/0", grant, rb_cyc, rb_stb); end
    vectors++; if (m1_ack !== 1'b0 || m1_err !== 1'b0) begin
      errors++; $display("FAIL t5_no_resp: got ack=%b err=%b exp 0/0", m1_ack, m1_err); end
    m0_cyc = 1; m0_stb = 1; m0_adr = 10'h070;
    tick(); #1;
    vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL t5_held: got %b exp 00", grant); end
    rst_n = 1;
    tick(); #1;
    vectors++; if (grant !== 2'b01) begin errors++; $display("FAIL t5_tie: got %b exp 01", grant); end
    idle_masters();
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie_round_robin();
    test_burst_cap();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
